// File: rtl/std_gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller with binary and gray-coded read/write pointers.
// Flags are derived from the next-state gray pointers and registered, so they carry no extra latency.
module std_gray_fifo_ctrl #(
  parameter int DEPTH       = 16,
  parameter int AFULL_LEVEL = DEPTH - 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pop,
  output logic          o_push_ack,
  output logic          o_pop_ack,
  output logic [AW-1:0] o_wr_addr,
  output logic [AW-1:0] o_rd_addr,
  output logic [AW:0]   o_wr_ptr_gray,
  output logic [AW:0]   o_rd_ptr_gray,
  output logic [AW:0]   o_count,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_almost_full,
  output logic          o_overflow,
  output logic          o_underflow
);

  localparam int PW = AW + 1;
  localparam logic [AW:0] AFULL_LVL = PW'(AFULL_LEVEL);
  // Inverting the two MSBs of the read gray pointer gives the write gray pointer
  // exactly DEPTH entries ahead; the shifted mask also covers AW == 1.
  localparam logic [AW:0] FULL_MASK = PW'(3) << (AW - 1);

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [AW:0] wbin, rbin;
  logic [AW:0] wbin_nxt, rbin_nxt;
  logic [AW:0] wgray_nxt, rgray_nxt;
  logic [AW:0] count_nxt;
  logic        empty_nxt, full_nxt, afull_nxt;

  assign o_push_ack = i_push & ~o_full;
  assign o_pop_ack  = i_pop  & ~o_empty;
  assign o_wr_addr  = wbin[AW-1:0];
  assign o_rd_addr  = rbin[AW-1:0];

  always_comb begin
    wbin_nxt  = wbin + PW'(o_push_ack);
    rbin_nxt  = rbin + PW'(o_pop_ack);
    wgray_nxt = bin2gray(wbin_nxt);
    rgray_nxt = bin2gray(rbin_nxt);
    count_nxt = wbin_nxt - rbin_nxt;
    empty_nxt = (wgray_nxt == rgray_nxt);
    full_nxt  = (wgray_nxt == (rgray_nxt ^ FULL_MASK));
    afull_nxt = (count_nxt >= AFULL_LVL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wbin          <= '0;
      rbin          <= '0;
      o_wr_ptr_gray <= '0;
      o_rd_ptr_gray <= '0;
      o_count       <= '0;
      o_empty       <= 1'b1;
      o_full        <= 1'b0;
      o_almost_full <= 1'b0;
      o_overflow    <= 1'b0;
      o_underflow   <= 1'b0;
    end else if (i_clear) begin
      wbin          <= '0;
      rbin          <= '0;
      o_wr_ptr_gray <= '0;
      o_rd_ptr_gray <= '0;
      o_count       <= '0;
      o_empty       <= 1'b1;
      o_full        <= 1'b0;
      o_almost_full <= 1'b0;
      o_overflow    <= 1'b0;
      o_underflow   <= 1'b0;
    end else begin
      wbin          <= wbin_nxt;
      rbin          <= rbin_nxt;
      o_wr_ptr_gray <= wgray_nxt;
      o_rd_ptr_gray <= rgray_nxt;
      o_count       <= count_nxt;
      o_empty       <= empty_nxt;
      o_full        <= full_nxt;
      o_almost_full <= afull_nxt;
      o_overflow    <= o_overflow  | (i_push & o_full);
      o_underflow   <= o_underflow | (i_pop  & o_empty);
    end
  end

  a_gray_wr: assert property (@(posedge i_clk) disable iff (i_rst) o_wr_ptr_gray == bin2gray(wbin));
  a_gray_rd: assert property (@(posedge i_clk) disable iff (i_rst) o_rd_ptr_gray == bin2gray(rbin));
  a_flags:   assert property (@(posedge i_clk) disable iff (i_rst) !(o_full && o_empty));

endmodule

// File: tb/tb_std_gray_fifo_ctrl.sv
// Directed bench for std_gray_fifo_ctrl at DEPTH=4, AFULL_LEVEL=3, plus a short
// model-checked random run with an asynchronous reset mid-run.
module tb_std_gray_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst, clr, push, pop;
  logic       push_ack, pop_ack;
  logic [1:0] wr_addr, rd_addr;
  logic [2:0] wr_gray, rd_gray, count;
  logic       empty, full, afull, ovf, unf;

  int tests = 0;
  int fails = 0;

  std_gray_fifo_ctrl #(.DEPTH(4), .AFULL_LEVEL(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_clear(clr), .i_push(push), .i_pop(pop),
    .o_push_ack(push_ack), .o_pop_ack(pop_ack),
    .o_wr_addr(wr_addr), .o_rd_addr(rd_addr),
    .o_wr_ptr_gray(wr_gray), .o_rd_ptr_gray(rd_gray),
    .o_count(count), .o_empty(empty), .o_full(full), .o_almost_full(afull),
    .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] b2g(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply requests, leave time for comb acks, then take one edge and settle.
  task automatic drive(input logic p, input logic q, input logic c);
    push = p; pop = q; clr = c;
    #2;
  endtask

  task automatic edge_settle();
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  logic [2:0] mw, mr, prev_w, prev_r, m_cnt;
  logic       m_ovf, m_unf, m_full, m_empty, p, q, pa, qa;

  initial begin
    rst = 1'b1; clr = 1'b0; push = 1'b0; pop = 1'b0;
    #3;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_wgray", wr_gray, 3'b000);
    check("rst_rgray", rd_gray, 3'b000);
    check("rst_ovf_unf", {ovf, unf}, 2'b00);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    edge_settle();
    check("idle_empty", empty, 1);
    check("idle_count", count, 0);

    // Fill to full
    drive(1, 0, 0); check("push1_ack", push_ack, 1); edge_settle();
    check("push1_gray", wr_gray, 3'b001); check("push1_cnt", count, 1); check("push1_af", afull, 0);
    drive(1, 0, 0); edge_settle();
    check("push2_gray", wr_gray, 3'b011); check("push2_cnt", count, 2); check("push2_af", afull, 0);
    drive(1, 0, 0); edge_settle();
    check("push3_gray", wr_gray, 3'b010); check("push3_af", afull, 1); check("push3_full", full, 0);
    drive(1, 0, 0); check("push4_ack", push_ack, 1); edge_settle();
    check("push4_gray", wr_gray, 3'b110); check("push4_full", full, 1); check("push4_cnt", count, 4);
    check("push4_waddr", wr_addr, 0);
    drive(1, 0, 0); check("push5_ack", push_ack, 0); edge_settle();
    check("push5_ovf", ovf, 1); check("push5_gray", wr_gray, 3'b110); check("push5_cnt", count, 4);

    // Push+pop while full: only the pop is taken
    drive(1, 1, 0); check("pp_full_pack", push_ack, 0); check("pp_full_qack", pop_ack, 1); edge_settle();
    check("pp_full_cnt", count, 3); check("pp_full_full", full, 0);
    check("pp_full_rgray", rd_gray, 3'b001); check("pp_full_wgray", wr_gray, 3'b110);
    check("pp_full_raddr", rd_addr, 1);

    // Clear
    drive(0, 0, 1); edge_settle();
    check("clr_ovf", ovf, 0); check("clr_empty", empty, 1); check("clr_cnt", count, 0);
    check("clr_ptrs", {wr_gray, rd_gray}, 6'b0);

    // Push+pop while empty: only the push is taken
    drive(1, 1, 0); check("pp_emp_pack", push_ack, 1); check("pp_emp_qack", pop_ack, 0); edge_settle();
    check("pp_emp_cnt", count, 1); check("pp_emp_unf", unf, 1); check("pp_emp_empty", empty, 0);

    // Streaming 20 cycles, pointers wrap
    mw = 3'd1; mr = 3'd0;
    for (int unsigned i = 0; i < 20; i++) begin
      prev_w = wr_gray; prev_r = rd_gray;
      drive(1, 1, 0); edge_settle();
      mw = mw + 3'd1; mr = mr + 3'd1;
      check("stream_cnt", count, 1);
      check("stream_wgray", wr_gray, b2g(mw));
      check("stream_rgray", rd_gray, b2g(mr));
      check("stream_wstep", $countones(prev_w ^ wr_gray), 1);
      check("stream_rstep", $countones(prev_r ^ rd_gray), 1);
      check("stream_waddr", wr_addr, mw[1:0]);
    end

    // Underflow then clear
    drive(0, 0, 1); edge_settle();
    drive(0, 1, 0); check("unf_qack", pop_ack, 0); edge_settle();
    check("unf_set", unf, 1);
    drive(0, 0, 1); edge_settle();
    check("unf_clr", unf, 0); check("unf_clr_empty", empty, 1);

    // Random run against a reference model
    mw = '0; mr = '0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int unsigned i = 0; i < 600; i++) begin
      if (i == 300) begin
        // Async reset between clock edges
        #2; rst = 1'b1; #1;
        check("arst_cnt", count, 0); check("arst_empty", empty, 1);
        check("arst_full", full, 0); check("arst_ptrs", {wr_gray, rd_gray}, 6'b0);
        check("arst_err", {ovf, unf}, 2'b00);
        @(posedge clk); #1; rst = 1'b0;
        mw = '0; mr = '0; m_ovf = 1'b0; m_unf = 1'b0;
      end
      p = 1'($urandom_range(0, 1));
      q = 1'($urandom_range(0, 1));
      m_cnt = mw - mr;
      m_full = (m_cnt == 3'd4);
      m_empty = (m_cnt == 3'd0);
      pa = p & ~m_full;
      qa = q & ~m_empty;
      drive(p, q, 0);
      check("rnd_pack", push_ack, pa);
      check("rnd_qack", pop_ack, qa);
      edge_settle();
      m_ovf = m_ovf | (p & m_full);
      m_unf = m_unf | (q & m_empty);
      mw = mw + 3'(pa); mr = mr + 3'(qa);
      m_cnt = mw - mr;
      check("rnd_cnt", count, m_cnt);
      check("rnd_empty", empty, m_cnt == 3'd0);
      check("rnd_full", full, m_cnt == 3'd4);
      check("rnd_af", afull, m_cnt >= 3'd3);
      check("rnd_wgray", wr_gray, b2g(mw));
      check("rnd_rgray", rd_gray, b2g(mr));
      check("rnd_err", {ovf, unf}, {m_ovf, m_unf});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
